cfg_dprio_csr_chain_loader: RTL



---
 rtl/cfg_dprio_csr_chain_loader_if.sv | 28 ++
 rtl/cfg_dprio_csr_chain_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cfg_dprio_csr_chain_loader_if.sv
// rtl/cfg_dprio_csr_chain_loader_if.sv - word handshake, serial chain and status bundle for the CSR chain loader
interface cfg_dprio_csr_chain_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word_data;
    logic                  word_ready;
    logic                  csr_in;
    logic                  csr_en;
    logic                  csr_out;
    logic                  rdbk_valid;
    logic [DATA_WIDTH-1:0] rdbk_data;
    logic                  busy;
    logic                  done;
    logic                  aborted;

    modport master (
        input  start, abort, word_valid, word_data, csr_out,
        output word_ready, csr_in, csr_en, rdbk_valid, rdbk_data, busy, done, aborted
    );

    modport slave (
        output start, abort, word_valid, word_data, csr_out,
        input  word_ready, csr_in, csr_en, rdbk_valid, rdbk_data, busy, done, aborted
    );
endinterface

// File: rtl/cfg_dprio_csr_chain_loader.sv
// rtl/cfg_dprio_csr_chain_loader.sv - shifts parallel words MSB-first into a DPRIO CSR chain and returns the tail bits as readback words
module cfg_dprio_csr_chain_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    cfg_dprio_csr_chain_loader_if.master   bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                state, state_next;
    logic [BW-1:0]         bit_cnt;
    logic [WW-1:0]         word_cnt;
    logic [DATA_WIDTH-2:0] shreg;
    logic [DATA_WIDTH-2:0] rdsh;
    logic [DATA_WIDTH-1:0] rdsh_next;
    logic [DATA_WIDTH-1:0] rdbk_data;
    logic                  csr_in, csr_en, rdbk_valid, done, aborted;
    logic                  word_ready, accept, last_bit, last_word, abort_hit;

    assign bus.word_ready = word_ready;
    assign bus.csr_in     = csr_in;
    assign bus.csr_en     = csr_en;
    assign bus.rdbk_valid = rdbk_valid;
    assign bus.rdbk_data  = rdbk_data;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done;
    assign bus.aborted    = aborted;

    // the chain tail is sampled on every edge the chain is enabled
    assign rdsh_next = {rdsh, bus.csr_out};

    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        abort_hit  = bus.abort && (state != IDLE);
        last_bit   = (state == SHIFT) && (bit_cnt == BIT_LAST);
        last_word  = (word_cnt == WORD_LAST);
        if (state == LOAD) begin
            word_ready = !bus.abort;
        end else if (last_bit && !last_word) begin
            word_ready = !bus.abort;
        end
        accept = word_ready && bus.word_valid;
        case (state)
            IDLE:    if (bus.start && !bus.abort) state_next = LOAD;
            LOAD:    if (accept) state_next = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    if (last_word)    state_next = DONE;
                    else if (!accept) state_next = LOAD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            rdsh       <= '0;
            rdbk_data  <= '0;
            csr_in     <= 1'b0;
            csr_en     <= 1'b0;
            rdbk_valid <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_next;
            rdbk_valid <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            if (abort_hit) begin
                // partial readback is dropped; the chain keeps whatever was shifted so far
                aborted  <= 1'b1;
                csr_en   <= 1'b0;
                csr_in   <= 1'b0;
                rdsh     <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else begin
                if (csr_en) begin
                    rdsh <= rdsh_next[DATA_WIDTH-2:0];
                    if (last_bit) begin
                        rdbk_data  <= rdsh_next;
                        rdbk_valid <= 1'b1;
                    end
                end
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            word_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            shreg   <= bus.word_data[DATA_WIDTH-2:0];
                            csr_in  <= bus.word_data[DATA_WIDTH-1];
                            csr_en  <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        if (!last_bit) begin
                            csr_in  <= shreg[DATA_WIDTH-2];
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (accept) begin
                            // next word follows with no gap in csr_en
                            shreg    <= bus.word_data[DATA_WIDTH-2:0];
                            csr_in   <= bus.word_data[DATA_WIDTH-1];
                            bit_cnt  <= '0;
                            word_cnt <= word_cnt + 1'b1;
                        end else begin
                            csr_en  <= 1'b0;
                            csr_in  <= 1'b0;
                            bit_cnt <= '0;
                            if (last_word) done <= 1'b1;
                            else           word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
